// File: rtl/booth_pp_accumulator.sv
// ---------------------------------------------------------------------------
// booth_pp_accumulator
//
// Sequential radix-16 Booth multiplier core. One operand pair is accepted in
// IDLE, then one 5-bit Booth window of the multiplier is presented per RUN
// cycle to an external Booth encoder / partial-product block. The 64-bit
// partial product it returns is shifted by 4*i and accumulated. The product
// is offered in DONE under a valid/ready handshake.
//
// Optional build macro:
//   BOOTH_EARLY_TERM_EN - leave RUN early once every remaining Booth digit
//                         is known to be zero.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   in_valid   operand pair valid
//   in_ready   core can accept operands (IDLE only)
//   A_in       multiplicand, unsigned
//   B_in       multiplier, two's-complement signed
//   X          multiplicand to encoder (registered A_in)
//   Y          current Booth window to encoder, {B[4i+3:4i], B[4i-1]}
//   PP         encoder result for X,Y (combinational, same cycle)
//   out_valid  product valid (DONE)
//   out_ready  downstream accepts product
//   P          product A*B modulo 2^(2*WIDTH)
//   busy       high in RUN
// ---------------------------------------------------------------------------
module booth_pp_accumulator #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = WIDTH / 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A_in,
  input  logic [WIDTH-1:0]     B_in,
  output logic [WIDTH-1:0]     X,
  output logic [4:0]           Y,
  input  logic [2*WIDTH-1:0]   PP,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   P,
  output logic                 busy
);

  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t               state;
  state_t               state_next;

  logic [WIDTH-1:0]     x_reg;
  logic [WIDTH-1:0]     b_reg;
  logic [2*WIDTH-1:0]   acc;
  logic [CNT_W-1:0]     digit;

  logic [CNT_W+1:0]     shamt;       // 4*i, bit offset of the current digit
  logic [WIDTH:0]       b_ext;       // multiplier with the implicit B[-1]=0
  logic                 last_digit;
  logic                 early_done;

  assign shamt      = {digit, 2'b00};
  assign b_ext      = {b_reg, 1'b0};
  assign last_digit = (digit == CNT_W'(DIGITS - 1));

`ifdef BOOTH_EARLY_TERM_EN
  // Arithmetic shift replicates the sign bit, so B[WIDTH-1:4i+3] are all
  // equal exactly when the shifted value is all zeros or all ones. Every
  // later window is then 00000 or 11111 and contributes nothing.
  logic [WIDTH-1:0] b_upper;

  assign b_upper    = $signed(b_reg) >>> (shamt + (CNT_W + 2)'(3));
  assign early_done = !last_digit && ((&b_upper) || !(|b_upper));
`else
  assign early_done = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  // NOTE: reset is sampled on the clock edge, so it sits inside the clocked
  // block rather than in the sensitivity list; state uses non-blocking
  // assignment so every flop updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // Next state and handshake outputs
  // ---------------------------------------------------------------------
  // NOTE: every output of this block gets a default first so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    out_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_digit || early_done) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Operand capture and shift-accumulate datapath
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      x_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      digit <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            x_reg <= A_in;
            b_reg <= B_in;
            acc   <= '0;
            digit <= '0;
          end
        end
        RUN: begin
          // PP is already a 2*WIDTH two's-complement value; bits shifted
          // past the top are discarded, giving the modulo product.
          acc   <= acc + (PP << shamt);
          digit <= digit + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Window i is {B[4i+3:4i], B[4i-1]}, i.e. bits 4i+4..4i of b_ext.
  always_comb begin
    Y = 5'b00000;
    if (state == RUN) begin
      Y = b_ext[shamt +: 5];
    end
  end

  assign X = x_reg;
  assign P = acc;   // stable in DONE: acc only changes in IDLE and RUN

endmodule
